instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle control sequencer for the jacaranda-8 core. It fetches 8-bit instructions over a request/acknowledge instruction-memory port and holds them in the instruction register that feeds the field decoder. It steps each instruction through decode, optional data-memory access and writeback, and issues the write-enable, PC-update and retire strobes to the datapath.

## Interface
- TIMEOUT, 16: handshake watchdog limit in cycles; legal range 2..255; used only with the macro below.
- clock  in  1  rising-edge system clock
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  level enable; sampled in IDLE and at the end of WB
- imem_req  out  1  instruction fetch request
- imem_addr  out  8  fetch address, always equal to `pc`
- imem_ack  in  1  fetch acknowledge; `imem_rdata` is valid in the same cycle
- imem_rdata  in  8  fetched instruction byte
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load; valid while `dmem_req` = 1
- dmem_ack  in  1  data access complete
- branch_taken  in  1  datapath branch condition, sampled in WB
- branch_target  in  8  datapath jump address, sampled in WB
- instr  out  8  instruction register; drives the decoder
- pc  out  8  program counter
- reg_we  out  1  register-file write strobe
- flag_we  out  1  compare-flag write strobe
- retired  out  1  one-cycle pulse per completed instruction
- busy  out  1  1 whenever state ≠ IDLE
- err  out  1  sticky handshake-timeout flag

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM=3, WB=4.
- Opcode is `instr[7:4]`. Opcode classes:
  - 14 = ld, 15 = st: memory class.
  - 10 = je, 11 = jmp: branch class.
  - 9 = cmp: compare.
  - All other opcodes: ALU class.
- IDLE → FETCH when `run` = 1.
- FETCH:
  - `imem_req` = 1 for the whole state.
  - On `imem_ack`: `instr` ← `imem_rdata`, next state DECODE.
- DECODE: lasts one cycle.
  - Memory class → MEM.
  - Otherwise → WB.
- MEM:
  - `dmem_req` = 1; `dmem_we` = 1 for st, 0 for ld.
  - On `dmem_ack` → WB.
- WB: lasts one cycle; `retired` = 1.
  - `reg_we` = 1 for ALU class and ld. It is 0 for cmp, branch class and st.
  - `flag_we` = 1 only for cmp.
  - PC update: `pc` ← `branch_target` if the opcode is branch class and `branch_taken` = 1. Otherwise `pc` ← `pc` + 1, mod 256 (0xFF wraps to 0x00).
  - Next state: FETCH if `run` = 1, else IDLE.
- `run` falling mid-instruction does not abort; the current instruction completes through WB, then the block goes to IDLE.
- `imem_ack` outside FETCH and `dmem_ack` outside MEM are ignored.
- `reg_we`, `flag_we`, `retired`, `imem_req`, `dmem_req`, `dmem_we` and `busy` are decoded from the state register only. They are glitch-free and carry no combinational path from any input.

## Timing
- Reset values:
  - State IDLE; `pc` = 0x00; `instr` = 0x00; `err` = 0.
  - All strobes and requests 0.
- `reset_n` low forces reset values asynchronously, in any state; outstanding requests drop immediately.
- Requests may only drop after their ack. Any pending acknowledge is discarded on reset.
- Zero-wait memory (ack in the first request cycle), per instruction:
  - Non-memory instruction: 3 cycles (FETCH, DECODE, WB).
  - ld/st: 4 cycles.
- Each wait cycle on either port adds exactly one cycle.
- First fetch starts the cycle after `run` is sampled high in IDLE.
- New `pc` is visible on `imem_addr` in the FETCH cycle following WB.

## Configuration
- `INSTR_SEQ_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on entry to FETCH or MEM and increments each cycle without ack.
  - When the count reaches TIMEOUT − 1 with no ack: `err` ← 1, state → IDLE, requests drop. `pc` and `instr` are unchanged and no `retired` pulse is issued.
  - `err` clears only on reset.
  - While `err` = 1, IDLE ignores `run`.
- Not defined: no counter; `err` is tied to 0; the handshakes wait indefinitely.

## Test plan
- Reset, `run` = 1, imem returns 0x14 (add) with zero wait → FETCH/DECODE/WB; `reg_we` pulses in cycle 3; `pc` goes 0x00 → 0x01; `retired` = 1 pulse.
- Fetch 0xE1 (ld), `dmem_ack` delayed 3 cycles → `dmem_req` = 1 for 4 cycles with `dmem_we` = 0; `reg_we` is asserted in WB; total 7 cycles.
- Fetch 0xB0 (jmp) with `branch_taken` = 1, `branch_target` = 0x40 → `reg_we` = 0; next `imem_addr` = 0x40. Fetch 0x90 (cmp) → `flag_we` = 1, `reg_we` = 0.
- `pc` = 0xFF, non-branch instruction → next `imem_addr` = 0x00. Drop `run` during MEM of a st (0xF0) → instruction retires, then IDLE with `busy` = 0.
- Assert `reset_n` = 0 mid-MEM → `dmem_req` and state clear immediately, without waiting for a clock edge; `pc` = 0x00.
- With `INSTR_SEQ_TIMEOUT_EN` and TIMEOUT = 16, withhold `imem_ack` → `err` = 1 after 16 FETCH cycles; IDLE; `run` is ignored until reset.

Source files
------------

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle control sequencer for the jacaranda-8 core. Each instruction
// runs FETCH -> DECODE -> (MEM) -> WB. The instruction is fetched over a
// req/ack instruction-memory port and held in the instruction register.
// The sequencer issues the register-file, flag, PC-update and retire
// strobes to the datapath.
//
// Optional feature: define INSTR_SEQ_TIMEOUT_EN to enable a handshake
// watchdog. When it is enabled, a fetch or data access that waits
// TIMEOUT cycles without an ack sets the sticky err flag and returns the
// sequencer to IDLE.
//
// Parameters
//   TIMEOUT        watchdog limit in cycles (2..255)
// Ports
//   clock          rising-edge system clock
//   reset_n        asynchronous active-low reset
//   run            level enable, sampled in IDLE and at the end of WB
//   imem_req/addr  instruction fetch request and address (address = pc)
//   imem_ack/rdata fetch acknowledge and instruction byte
//   dmem_req/we    data access request, 1 = store / 0 = load
//   dmem_ack       data access complete
//   branch_taken   branch condition, sampled in WB
//   branch_target  jump address, sampled in WB
//   instr          instruction register
//   pc             program counter
//   reg_we         register-file write strobe (WB)
//   flag_we        compare-flag write strobe (WB)
//   retired        one-cycle pulse per completed instruction
//   busy           high whenever the sequencer is not idle
//   err            sticky handshake-timeout flag
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       run,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_rdata,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    output logic [7:0] instr,
    output logic [7:0] pc,
    output logic       reg_we,
    output logic       flag_we,
    output logic       retired,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    // Reject an out-of-range watchdog limit when the design is elaborated.
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("instr_sequencer: TIMEOUT must be in 2..255");
    end

    state_t state;
    state_t state_next;
    logic   err_q;
    logic   timeout_hit;

    // Opcode classes are decoded from the instruction register. They are
    // only consulted once the register holds the current instruction.
    logic [3:0] opcode;
    logic       is_ld;
    logic       is_st;
    logic       is_mem;
    logic       is_branch;
    logic       is_cmp;
    logic       writes_reg;

    assign opcode     = instr[7:4];
    assign is_ld      = (opcode == 4'd14);
    assign is_st      = (opcode == 4'd15);
    assign is_mem     = is_ld | is_st;
    assign is_branch  = (opcode == 4'd10) | (opcode == 4'd11);
    assign is_cmp     = (opcode == 4'd9);
    assign writes_reg = !(is_cmp | is_branch | is_st);

    assign imem_addr = pc;
    assign err       = err_q;

`ifdef INSTR_SEQ_TIMEOUT_EN
    // Watchdog. The counter restarts on every entry to a handshake state
    // and advances on each cycle that state waits without an ack. Reaching
    // TIMEOUT-1 while the ack is still missing means TIMEOUT cycles have
    // been spent waiting, counting the current one.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wait_cnt;

    assign timeout_hit = (wait_cnt == TIMEOUT_LAST) &&
                         (((state == FETCH) && !imem_ack) ||
                          ((state == MEM) && !dmem_ack));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 8'd0;
        end else if ((state_next != state) &&
                     ((state_next == FETCH) || (state_next == MEM))) begin
            wait_cnt <= 8'd0;
        end else if (((state == FETCH) && !imem_ack) ||
                     ((state == MEM) && !dmem_ack)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // The error flag is sticky until reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    // Without the watchdog the handshakes wait indefinitely.
    assign timeout_hit = 1'b0;
    assign err_q       = 1'b0;
`endif

    // Next-state logic. A falling run never aborts an instruction, because
    // run is only consulted in IDLE and at the end of WB. While err is set,
    // IDLE refuses to start.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (run && !err_q) state_next = FETCH;
            FETCH:   begin
                         if (imem_ack)         state_next = DECODE;
                         else if (timeout_hit) state_next = IDLE;
                     end
            DECODE:  state_next = is_mem ? MEM : WB;
            MEM:     begin
                         if (dmem_ack)         state_next = WB;
                         else if (timeout_hit) state_next = IDLE;
                     end
            WB:      state_next = run ? FETCH : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Main sequencer register. Every strobe is a flop loaded from the
    // decode of the state being entered. Outputs therefore never glitch
    // and have no combinational path from an input. The asynchronous reset
    // drops all requests at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            pc       <= 8'h00;
            instr    <= 8'h00;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            reg_we   <= 1'b0;
            flag_we  <= 1'b0;
            retired  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state <= state_next;

            if ((state == FETCH) && imem_ack) begin
                instr <= imem_rdata;
            end

            // A taken branch loads the target. Otherwise the pc wraps
            // naturally at 8 bits.
            if (state == WB) begin
                if (is_branch && branch_taken) pc <= branch_target;
                else                           pc <= pc + 8'd1;
            end

            imem_req <= (state_next == FETCH);
            dmem_req <= (state_next == MEM);
            dmem_we  <= (state_next == MEM) && is_st;
            reg_we   <= (state_next == WB) && writes_reg;
            flag_we  <= (state_next == WB) && is_cmp;
            retired  <= (state_next == WB);
            busy     <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed self-checking bench for instr_sequencer. Each scenario task
// drives its own stimulus and compares against hand-computed values. DUT
// outputs are sampled on the falling clock edge, and inputs are changed
// there as well.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_sequencer;

    logic       clock;
    logic       reset_n;
    logic       run;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [7:0] instr;
    logic [7:0] pc;
    logic       reg_we;
    logic       flag_we;
    logic       retired;
    logic       busy;
    logic       err;

    int checks;
    int errors;

    instr_sequencer #(.TIMEOUT(16)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .run           (run),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ack      (dmem_ack),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr         (instr),
        .pc            (pc),
        .reg_we        (reg_we),
        .flag_we       (flag_we),
        .retired       (retired),
        .busy          (busy),
        .err           (err)
    );

    // 10 ns system clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Results gathered by exec_instr for one instruction
    int         r_cycles;
    int         r_reg_we;
    int         r_reg_we_cyc;
    int         r_flag_we;
    int         r_retired;
    int         r_dreq;
    int         r_dwe;
    logic [7:0] r_faddr;
    bit         r_hung;

    // Runs one instruction from IDLE and records what the strobes did.
    // The memories answer after the requested number of wait cycles. run
    // is dropped in FETCH, or in MEM when drop_at_mem is set.
    task automatic exec_instr(input logic [7:0] op, input int imem_wait,
                              input int dmem_wait, input bit drop_at_mem);
        int iw;
        int dw;
        iw = 0; dw = 0;
        r_cycles = 0; r_reg_we = 0; r_reg_we_cyc = 0; r_flag_we = 0;
        r_retired = 0; r_dreq = 0; r_dwe = 0; r_faddr = 8'h00; r_hung = 1'b1;
        run = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 64; k++) begin
            if (!busy) begin
                r_hung = 1'b0;
                break;
            end
            r_cycles++;
            if (!drop_at_mem || dmem_req) run = 1'b0;
            if (r_cycles == 1) r_faddr = imem_addr;
            if (reg_we) begin r_reg_we++; r_reg_we_cyc = r_cycles; end
            if (flag_we) r_flag_we++;
            if (retired) r_retired++;
            if (dmem_req) r_dreq++;
            if (dmem_req && dmem_we) r_dwe++;
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            if (imem_req) begin
                if (iw >= imem_wait) begin imem_ack = 1'b1; imem_rdata = op; end
                else iw++;
            end
            if (dmem_req) begin
                if (dw >= dmem_wait) dmem_ack = 1'b1;
                else dw++;
            end
            @(negedge clock);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        run = 1'b0;
        checks++;
        if (r_hung) begin
            errors++;
            $display("[TB] FAIL exec_hang op=%02h: still busy after 64 cycles (required idle)", op);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        run = 1'b0; imem_ack = 1'b0; imem_rdata = 8'h00; dmem_ack = 1'b0;
        branch_taken = 1'b0; branch_target = 8'h00;
        repeat (2) @(negedge clock);
        checks++;
        if ({busy, imem_req, dmem_req, dmem_we, reg_we, flag_we, retired, err} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got %08b required 00000000",
                     {busy, imem_req, dmem_req, dmem_we, reg_we, flag_we, retired, err});
        end
        checks++;
        if (pc !== 8'h00 || instr !== 8'h00 || imem_addr !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_regs: pc=%02h instr=%02h addr=%02h required 00/00/00",
                     pc, instr, imem_addr);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_alu();
        exec_instr(8'h14, 0, 0, 1'b0);
        checks++;
        if (r_cycles !== 3 || r_reg_we !== 1 || r_reg_we_cyc !== 3) begin
            errors++;
            $display("[TB] FAIL alu_timing: cycles=%0d reg_we=%0d at %0d required 3/1/3",
                     r_cycles, r_reg_we, r_reg_we_cyc);
        end
        checks++;
        if (r_retired !== 1 || r_flag_we !== 0 || r_dreq !== 0 || pc !== 8'h01 || instr !== 8'h14) begin
            errors++;
            $display("[TB] FAIL alu_result: retired=%0d flag_we=%0d dreq=%0d pc=%02h instr=%02h required 1/0/0/01/14",
                     r_retired, r_flag_we, r_dreq, pc, instr);
        end
    endtask

    task automatic test_load();
        exec_instr(8'hE1, 0, 3, 1'b0);
        checks++;
        if (r_cycles !== 7 || r_dreq !== 4 || r_dwe !== 0) begin
            errors++;
            $display("[TB] FAIL load_timing: cycles=%0d dmem_req=%0d dmem_we=%0d required 7/4/0",
                     r_cycles, r_dreq, r_dwe);
        end
        checks++;
        if (r_reg_we !== 1 || r_retired !== 1 || pc !== 8'h02 || r_faddr !== 8'h01) begin
            errors++;
            $display("[TB] FAIL load_result: reg_we=%0d retired=%0d pc=%02h faddr=%02h required 1/1/02/01",
                     r_reg_we, r_retired, pc, r_faddr);
        end
    endtask

    task automatic test_branch();
        branch_taken = 1'b1; branch_target = 8'h40;
        exec_instr(8'hB0, 1, 0, 1'b0);
        branch_taken = 1'b0;
        checks++;
        if (r_reg_we !== 0 || r_flag_we !== 0 || r_cycles !== 4 || pc !== 8'h40) begin
            errors++;
            $display("[TB] FAIL jmp_taken: reg_we=%0d flag_we=%0d cycles=%0d pc=%02h required 0/0/4/40",
                     r_reg_we, r_flag_we, r_cycles, pc);
        end
    endtask

    task automatic test_compare();
        branch_taken = 1'b1; branch_target = 8'h77;
        exec_instr(8'h90, 0, 0, 1'b0);
        branch_taken = 1'b0;
        checks++;
        if (r_faddr !== 8'h40) begin
            errors++;
            $display("[TB] FAIL branch_fetch_addr: got %02h required 40", r_faddr);
        end
        checks++;
        if (r_flag_we !== 1 || r_reg_we !== 0 || pc !== 8'h41) begin
            errors++;
            $display("[TB] FAIL cmp_strobes: flag_we=%0d reg_we=%0d pc=%02h required 1/0/41",
                     r_flag_we, r_reg_we, pc);
        end
    endtask

    task automatic test_je_not_taken();
        branch_taken = 1'b0; branch_target = 8'h10;
        exec_instr(8'hA0, 0, 0, 1'b0);
        checks++;
        if (pc !== 8'h42 || r_reg_we !== 0 || r_retired !== 1) begin
            errors++;
            $display("[TB] FAIL je_not_taken: pc=%02h reg_we=%0d retired=%0d required 42/0/1",
                     pc, r_reg_we, r_retired);
        end
    endtask

    task automatic test_pc_wrap();
        branch_taken = 1'b1; branch_target = 8'hFF;
        exec_instr(8'hB3, 0, 0, 1'b0);
        branch_taken = 1'b0;
        exec_instr(8'h25, 0, 0, 1'b0);
        checks++;
        if (r_faddr !== 8'hFF || pc !== 8'h00) begin
            errors++;
            $display("[TB] FAIL pc_wrap: faddr=%02h pc=%02h required FF/00", r_faddr, pc);
        end
        exec_instr(8'h31, 0, 0, 1'b0);
        checks++;
        if (r_faddr !== 8'h00 || pc !== 8'h01) begin
            errors++;
            $display("[TB] FAIL pc_after_wrap: faddr=%02h pc=%02h required 00/01", r_faddr, pc);
        end
    endtask

    task automatic test_store_run_drop();
        exec_instr(8'hF0, 0, 0, 1'b1);
        checks++;
        if (r_cycles !== 4 || r_dreq !== 1 || r_dwe !== 1 || r_reg_we !== 0) begin
            errors++;
            $display("[TB] FAIL store_strobes: cycles=%0d dreq=%0d dwe=%0d reg_we=%0d required 4/1/1/0",
                     r_cycles, r_dreq, r_dwe, r_reg_we);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (r_retired !== 1 || busy !== 1'b0 || pc !== 8'h02) begin
            errors++;
            $display("[TB] FAIL store_then_idle: retired=%0d busy=%b pc=%02h required 1/0/02",
                     r_retired, busy, pc);
        end
    endtask

    task automatic test_stray_ack();
        imem_ack = 1'b1; imem_rdata = 8'hEE; dmem_ack = 1'b1;
        repeat (2) @(negedge clock);
        imem_ack = 1'b0; dmem_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || instr !== 8'hF0 || pc !== 8'h02) begin
            errors++;
            $display("[TB] FAIL stray_ack: busy=%b instr=%02h pc=%02h required 0/F0/02",
                     busy, instr, pc);
        end
    endtask

    task automatic test_back_to_back();
        int ret;
        ret = 0;
        run = 1'b1;
        @(negedge clock);
        for (int c = 1; c <= 6; c++) begin
            if (retired) ret++;
            if (c == 6) run = 1'b0;
            imem_ack = imem_req;
            imem_rdata = 8'h12;
            @(negedge clock);
        end
        imem_ack = 1'b0;
        @(negedge clock);
        checks++;
        if (ret !== 2 || busy !== 1'b0 || pc !== 8'h04) begin
            errors++;
            $display("[TB] FAIL back_to_back: retired=%0d busy=%b pc=%02h required 2/0/04",
                     ret, busy, pc);
        end
    endtask

    task automatic test_reset_mid_mem();
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        imem_ack = 1'b1; imem_rdata = 8'hE2;
        @(negedge clock);
        imem_ack = 1'b0;
        @(negedge clock);
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_mem_setup: dmem_req=%b required 1", dmem_req);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || busy !== 1'b0 || pc !== 8'h00 || instr !== 8'h00) begin
            errors++;
            $display("[TB] FAIL async_reset: dmem_req=%b busy=%b pc=%02h instr=%02h required 0/0/00/00",
                     dmem_req, busy, pc, instr);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        run = 1'b1;
        @(negedge clock);
`ifdef INSTR_SEQ_TIMEOUT_EN
        for (int k = 0; k < 40; k++) begin
            if (!imem_req) break;
            n++;
            @(negedge clock);
        end
        checks++;
        if (n !== 16 || err !== 1'b1 || busy !== 1'b0 || pc !== 8'h00) begin
            errors++;
            $display("[TB] FAIL timeout: fetch_cycles=%0d err=%b busy=%b pc=%02h required 16/1/0/00",
                     n, err, busy, pc);
        end
        repeat (5) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || imem_req !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_blocks_run: busy=%b imem_req=%b err=%b required 0/0/1",
                     busy, imem_req, err);
        end
`else
        for (int k = 0; k < 20; k++) begin
            if (imem_req) n++;
            @(negedge clock);
        end
        checks++;
        if (n !== 20 || imem_req !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_timeout: fetch_cycles=%0d imem_req=%b err=%b required 20/1/0",
                     n, imem_req, err);
        end
`endif
        run = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_cleared: err=%b busy=%b required 0/0", err, busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu();
        test_load();
        test_branch();
        test_compare();
        test_je_not_taken();
        test_pc_wrap();
        test_store_run_drop();
        test_stray_ack();
        test_back_to_back();
        test_reset_mid_mem();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
